// File: rtl/decrypt_iter_pkg.sv
// Shared DES constants, permutation/S-box tables and the combinational pre/round/post helpers
// used by the iterative decryptor and its inverse key schedule.
package decrypt_iter_pkg;

  localparam int N_K = 64;
  localparam int N_B = 64;
  localparam int N_R = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
    logic [55:0] cd;
  } pre_t;

  // Right-rotate amount applied to CD ahead of decryption round d; entry 0 is never used.
  localparam logic [1:0] ROT_TAB [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
  };

  // Each S-box is four 16-nibble rows, row 0 in the most significant bits.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [47:0] e_perm(input logic [31:0] x);
    logic [47:0] y = '0;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y = '0;
    for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_T[5'(j)])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y = '0;
    for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y = '0;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [3:0] sbox(input logic [2:0] box, input logic [5:0] b);
    logic [5:0]   pos = {b[5], b[0], b[4:1]};
    logic [255:0] tab = SBOX[box];
    return tab[8'(255 - 4 * int'(pos)) -: 4];
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] sk);
    logic [47:0] x = e_perm(r) ^ sk;
    logic [31:0] s = '0;
    for (int j = 0; j < 8; j++) s[5'(31 - 4 * j) -: 4] = sbox(3'(j), x[6'(47 - 6 * j) -: 6]);
    return p_perm(s);
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  function automatic pre_t pre_processing(input logic [63:0] k, input logic [63:0] c);
    logic [63:0] ipv = ip_perm(c);
    pre_t p;
    p.l  = ipv[63:32];
    p.r  = ipv[31:0];
    p.cd = pc1_perm(k);
    return p;
  endfunction

  function automatic logic [63:0] round(input logic [31:0] l, input logic [31:0] r,
                                        input logic [47:0] sk);
    return {r, l ^ feistel(r, sk)};
  endfunction

  // Final halves are swapped before the inverse initial permutation.
  function automatic logic [63:0] post_processing(input logic [31:0] l, input logic [31:0] r);
    return fp_perm({r, l});
  endfunction

endpackage

// File: rtl/decrypt_iter_key_schedule_inv.sv
// Reverse-direction DES key schedule step: subkey for the current CD and the CD
// pre-rotated right for the following decryption round.
module key_schedule_inv
  import decrypt_iter_pkg::*;
(
  input  logic [55:0] x,
  input  logic [3:0]  i,
  output logic [47:0] k,
  output logic [55:0] r
);

  logic [3:0] next_i;
  logic [1:0] amt;

  // At i=15 the index wraps to the unused entry 0, which is harmless since r is then ignored.
  always_comb begin
    next_i = i + 4'd1;
    amt    = ROT_TAB[next_i];
    k      = pc2_perm(x);
    r      = {rotr28(x[55:28], amt), rotr28(x[27:0], amt)};
  end

endmodule

// File: rtl/decrypt_iter.sv
// Iterative DES decryptor, one Feistel round per clock behind a 4-phase req/ack handshake.
// Define DECRYPT_ZEROISE_EN to clear m, L, R and CD on the edge where ack is released.
module decrypt_iter
  import decrypt_iter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  output logic           ack,
  input  logic [N_K-1:0] k,
  input  logic [N_B-1:0] c,
  output logic [N_B-1:0] m
);

  localparam logic [3:0] LAST_ROUND = 4'(N_R - 1);

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    l_q, l_d, r_q, r_d;
  logic [55:0]    cd_q, cd_d;
  logic [N_B-1:0] m_q, m_d;
  logic           ack_q, ack_d;

  pre_t           pre;
  logic [63:0]    rnd;
  logic [47:0]    subkey;
  logic [55:0]    cd_next;

  key_schedule_inv u_ks (
    .x (cd_q),
    .i (cnt_q),
    .k (subkey),
    .r (cd_next)
  );

  always_comb begin
    pre     = pre_processing(k, c);
    rnd     = round(l_q, r_q, subkey);
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    cd_d    = cd_q;
    m_d     = m_q;
    ack_d   = ack_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          l_d     = pre.l;
          r_d     = pre.r;
          cd_d    = pre.cd;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        l_d  = rnd[63:32];
        r_d  = rnd[31:0];
        cd_d = cd_next;
        // The counter parks on the last round; only the load path returns it to zero.
        if (cnt_q == LAST_ROUND) begin
          m_d     = post_processing(rnd[63:32], rnd[31:0]);
          ack_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (!req) begin
          ack_d   = 1'b0;
          state_d = IDLE;
`ifdef DECRYPT_ZEROISE_EN
          m_d  = '0;
          l_d  = '0;
          r_d  = '0;
          cd_d = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      cd_q    <= '0;
      m_q     <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      cd_q    <= cd_d;
      m_q     <= m_d;
      ack_q   <= ack_d;
    end
  end

  assign ack = ack_q;
  assign m   = m_q;

endmodule

// File: tb/tb_decrypt_iter.sv
// Scoreboard bench for decrypt_iter: known vectors, disturbances, async reset and
// random round trips against a forward DES reference model.
module tb_decrypt_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        ack;
  logic [63:0] k, c, m;

  int          compared   = 0;
  int          mismatched = 0;
  logic [63:0] exp_q [$];

  localparam logic [63:0] V1K = 64'h133457799BBCDFF1;
  localparam logic [63:0] V1C = 64'h85E813540F0AB405;
  localparam logic [63:0] V1P = 64'h0123456789ABCDEF;
  localparam logic [63:0] V2K = 64'h0E329232EA6D0D73;
  localparam logic [63:0] V2C = 64'h0000000000000000;
  localparam logic [63:0] V2P = 64'h8787878787878787;

  localparam int IP_O = 0, FP_O = 64, E_O = 128, P_O = 176, PC1_O = 208, PC2_O = 264;

  decrypt_iter dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .ack (ack),
    .k   (k),
    .c   (c),
    .m   (m)
  );

  always #5 clk = ~clk;

  // IP, FP, E, P, PC1, PC2 concatenated; entries use 1-based MSB-first bit numbers.
  int tab [312] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7,
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25,
    32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1,
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25,
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4,
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32
  };

  logic [255:0] sb [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [63:0] perm(input logic [63:0] x, input int inw, input int off,
                                       input int outw);
    logic [63:0] y = '0;
    for (int j = 0; j < outw; j++) y[outw - 1 - j] = x[inw - tab[off + j]];
    return y;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input int s);
    return (s == 1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [31:0] ffun(input logic [31:0] r, input logic [47:0] sk);
    logic [63:0]  ex = perm({32'b0, r}, 32, E_O, 48);
    logic [47:0]  x  = ex[47:0] ^ sk;
    logic [31:0]  s  = '0;
    logic [5:0]   b;
    logic [255:0] box;
    int           rw, cl;
    for (int j = 0; j < 8; j++) begin
      b   = x[47 - 6 * j -: 6];
      rw  = {b[5], b[0]};
      cl  = b[4:1];
      box = sb[j];
      s[31 - 4 * j -: 4] = box[255 - 4 * (rw * 16 + cl) -: 4];
    end
    ex = perm({32'b0, s}, 32, P_O, 32);
    return ex[31:0];
  endfunction

  // Forward DES with the classic left-rotating key schedule.
  function automatic logic [63:0] des_encrypt(input logic [63:0] key, input logic [63:0] pt);
    logic [63:0] t  = perm(key, 64, PC1_O, 56);
    logic [27:0] cc = t[55:28];
    logic [27:0] dd = t[27:0];
    logic [31:0] l, r, tmp;
    logic [63:0] sk;
    t = perm(pt, 64, IP_O, 64);
    l = t[63:32];
    r = t[31:0];
    for (int i = 1; i <= 16; i++) begin
      cc  = rotl(cc, (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2);
      dd  = rotl(dd, (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2);
      sk  = perm({8'b0, cc, dd}, 56, PC2_O, 48);
      tmp = r;
      r   = l ^ ffun(r, sk[47:0]);
      l   = tmp;
    end
    return perm({r, l}, 64, FP_O, 64);
  endfunction

  function automatic logic [63:0] heldValue(input logic [63:0] pt);
`ifdef DECRYPT_ZEROISE_EN
    return 64'h0;
`else
    return pt;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] kk, input logic [63:0] cc, input logic [63:0] pt);
    exp_q.push_back(pt);
    k   = kk;
    c   = cc;
    req = 1'b1;
  endtask

  task automatic awaitResult(input string tag, input bit disturb, output int edges);
    logic [63:0] want;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (disturb && edges == 6) req = 1'b0;
      if (disturb && edges == 9) begin
        k = {$urandom, $urandom};
        c = {$urandom, $urandom};
      end
    end while (!ack && edges < 40);
    want = exp_q.pop_front();
    if (!ack) checkOutput({tag, " ack timeout"}, 64'(ack), 64'h1);
    else      checkOutput({tag, " m"}, m, want);
  endtask

  task automatic runOp(input string tag, input logic [63:0] kk, input logic [63:0] cc,
                       input logic [63:0] pt, input bit disturb);
    int edges;
    applyStimulus(kk, cc, pt);
    awaitResult(tag, disturb, edges);
    checkOutput({tag, " latency"}, 64'(edges), 64'd17);
    if (!disturb) begin
      @(posedge clk);
      #1;
      checkOutput({tag, " ack hold"}, 64'(ack), 64'h1);
      checkOutput({tag, " m hold"}, m, pt);
      req = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput({tag, " ack fall"}, 64'(ack), 64'h0);
    checkOutput({tag, " m after release"}, m, heldValue(pt));
  endtask

  initial begin
    logic [63:0] rk, rp;
    rst = 1'b0;
    req = 1'b0;
    k   = '0;
    c   = '0;
    #12;
    checkOutput("reset ack", 64'(ack), 64'h0);
    checkOutput("reset m", m, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle without req", 64'(ack), 64'h0);

    runOp("vec1", V1K, V1C, V1P, 1'b0);
    runOp("vec2", V2K, V2C, V2P, 1'b0);
    runOp("vec1 again", V1K, V1C, V1P, 1'b0);
    runOp("disturbed", V1K, V1C, V1P, 1'b1);

    applyStimulus(V1K, V1C, V1P);
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b0;
    req = 1'b0;
    #1;
    checkOutput("async reset ack", 64'(ack), 64'h0);
    checkOutput("async reset m", m, 64'h0);
    void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    checkOutput("reset held ack", 64'(ack), 64'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    runOp("after reset", V1K, V1C, V1P, 1'b0);

    for (int n = 0; n < 200; n++) begin
      rk = {$urandom, $urandom};
      rp = {$urandom, $urandom};
      runOp($sformatf("random %0d", n), rk, des_encrypt(rk, rp), rp, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
